alu: RTL and testbench



---
 rtl/alu.sv | 91 +++++++++
 tb/tb_alu.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 32-bit execute-stage ALU with a 1-cycle registered result.
// Defining ALU_FLAGS_EN adds registered zero and signed-overflow outputs.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUOp,
`ifdef ALU_FLAGS_EN
    output logic             zero,
    output logic             overflow,
`endif
    output logic [WIDTH-1:0] C
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SRL = 3'b100,
        OP_SRA = 3'b101,
        OP_XOR = 3'b110,
        OP_SLL = 3'b111
    } alu_op_e;

    // Only the low bits of B form the shift amount; the rest are ignored.
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] c_d, c_q;

    assign shamt = B[SHW-1:0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        c_d = '0;
        case (alu_op_e'(ALUOp))
            OP_ADD:  c_d = A + B;
            OP_SUB:  c_d = A - B;
            OP_AND:  c_d = A & B;
            OP_OR:   c_d = A | B;
            OP_SRL:  c_d = A >> shamt;
            OP_SRA:  c_d = WIDTH'($signed(A) >>> shamt);
            OP_XOR:  c_d = A ^ B;
            OP_SLL:  c_d = A << shamt;
            default: c_d = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) c_q <= '0;
        else       c_q <= c_d;
    end

    assign C = c_q;

`ifdef ALU_FLAGS_EN
    logic zero_d, zero_q;
    logic overflow_d, overflow_q;

    // Overflow on ADD: same-sign operands, result sign flips.
    // Overflow on SUB: different-sign operands, result sign differs from A.
    always_comb begin
        zero_d     = (c_d == '0);
        overflow_d = 1'b0;
        case (alu_op_e'(ALUOp))
            OP_ADD:  overflow_d = (A[WIDTH-1] == B[WIDTH-1]) && (c_d[WIDTH-1] != A[WIDTH-1]);
            OP_SUB:  overflow_d = (A[WIDTH-1] != B[WIDTH-1]) && (c_d[WIDTH-1] != A[WIDTH-1]);
            default: overflow_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign zero     = zero_q;
    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expected results, a monitor pops and compares.
module tb_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [2:0]  ALUOp;
    logic [31:0] C;
`ifdef ALU_FLAGS_EN
    logic        zero, overflow;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] c;
        logic        z;
        logic        v;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .ALUOp   (ALUOp),
`ifdef ALU_FLAGS_EN
        .zero    (zero),
        .overflow(overflow),
`endif
        .C       (C)
    );

    // Reference model built from arithmetic definitions rather than operators on bit vectors.
    function automatic exp_t model(input string name, input logic rst,
                                   input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        exp_t e;
        longint unsigned ua = a, ub = b, p = 1, two32 = 64'h1_0000_0000;
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s, q;
        int sh = int'(b % 32);
        repeat (sh) p = p * 2;
        e.name = name;
        e.v    = 1'b0;
        case (op)
            3'd0: begin
                e.c = 32'((ua + ub) % two32);
                s = sa + sb;
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                e.c = 32'((ua + two32 - ub) % two32);
                s = sa - sb;
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: e.c = a & b;
            3'd3: e.c = a | b;
            3'd4: e.c = 32'(ua / p);
            3'd5: begin
                q = sa / longint'(p);
                if (sa < 0 && (sa % longint'(p)) != 0) q = q - 1;
                e.c = 32'(q);
            end
            3'd6: e.c = a ^ b;
            default: e.c = 32'((ua * p) % two32);
        endcase
        if (rst) begin
            e.c = '0;
            e.v = 1'b0;
            e.z = 1'b0;
        end else begin
            e.z = (e.c == 32'd0);
        end
        return e;
    endfunction

    task automatic issue(input string name, input logic rst,
                         input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        @(negedge clk);
        reset = rst;
        A     = a;
        B     = b;
        ALUOp = op;
        exp_q.push_back(model(name, rst, a, b, op));
    endtask

    // Monitor: the result of each sampled operation is visible just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if (C !== e.c) begin
                    bad++;
                    $display("FAIL %s: C got %h want %h", e.name, C, e.c);
                end
`ifdef ALU_FLAGS_EN
                total++;
                if (zero !== e.z) begin
                    bad++;
                    $display("FAIL %s.zero: got %b want %b", e.name, zero, e.z);
                end
                total++;
                if (overflow !== e.v) begin
                    bad++;
                    $display("FAIL %s.overflow: got %b want %b", e.name, overflow, e.v);
                end
`endif
            end
        end
    end

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        logic        rrst;
        int          guard;

        reset = 1'b1; A = '0; B = '0; ALUOp = '0;

        issue("reset0", 1'b1, 32'd10, 32'd5, 3'd0);
        issue("reset1", 1'b1, 32'd10, 32'd5, 3'd0);
        issue("add_after_reset", 1'b0, 32'd10, 32'd5, 3'd0);

        issue("sub_10_5", 1'b0, 32'd10, 32'd5, 3'd1);
        issue("sub_wrap", 1'b0, 32'd0, 32'd1, 3'd1);

        issue("and", 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 3'd2);
        issue("or",  1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 3'd3);
        issue("xor", 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 3'd6);

        issue("srl4", 1'b0, 32'h80000010, 32'h00000024, 3'd4);
        issue("sra4", 1'b0, 32'h80000010, 32'h00000024, 3'd5);
        issue("sll4", 1'b0, 32'h80000010, 32'h00000024, 3'd7);

        issue("sra31", 1'b0, 32'h80000000, 32'h0000001F, 3'd5);
        issue("srl_sh0", 1'b0, 32'hDEADBEEF, 32'hFFFFFFE0, 3'd4);
        issue("sll_sh0", 1'b0, 32'h12345678, 32'h00000020, 3'd7);
        issue("sra31_pos", 1'b0, 32'h7FFFFFFF, 32'h0000003F, 3'd5);

        issue("b2b_add", 1'b0, 32'd7, 32'd3, 3'd0);
        issue("b2b_sub", 1'b0, 32'd7, 32'd3, 3'd1);
        issue("b2b_and", 1'b0, 32'd7, 32'd3, 3'd2);
        issue("b2b_add2", 1'b0, 32'd7, 32'd3, 3'd0);
        issue("b2b_sub_reset", 1'b1, 32'd7, 32'd3, 3'd1);
        issue("b2b_and_post", 1'b0, 32'd7, 32'd3, 3'd2);

        issue("ovf_add", 1'b0, 32'h7FFFFFFF, 32'd1, 3'd0);
        issue("zero_sub", 1'b0, 32'd5, 32'd5, 3'd1);
        issue("ovf_sub", 1'b0, 32'h80000000, 32'd1, 3'd1);
        issue("ovf_add_neg", 1'b0, 32'h80000000, 32'h80000000, 3'd0);

        for (int i = 0; i < 400; i++) begin
            ra   = $urandom();
            rb   = $urandom();
            rop  = 3'($urandom_range(0, 7));
            rrst = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 7) == 0) ra = {ra[31], 31'h0} | (ra & 32'hFF);
            issue("rand", rrst, ra, rb, rop);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d results never checked, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
